// File: rtl/bin_bcd_mux_display.sv
// Sequential binary-to-BCD converter (double dabble, one iteration per clock)
// feeding a multiplexed common-anode seven-segment display with optional
// leading-zero blanking. The display only ever shows completed conversions.
module bin_bcd_mux_display #(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            segment_data,
    output logic [DIGITS-1:0]     AN
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // 10^n as a 64-bit constant, used to prove the BCD field can hold 2^DATA_W-1
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Reject parameter sets the datapath cannot represent
    if (DATA_W < 4 || DATA_W > 20) begin : g_bad_data_w
        $fatal(1, "bin_bcd_mux_display: DATA_W must be in 4..20");
    end
    if (pow10(DIGITS) <= (64'd1 << DATA_W)) begin : g_bad_digits
        $fatal(1, "bin_bcd_mux_display: DIGITS too small for DATA_W");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $fatal(1, "bin_bcd_mux_display: REFRESH_DIV must be at least 2");
    end

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-decimal codes blank
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               start;
    logic               step;
    logic               finish;
    logic [DATA_W-1:0]  bin_reg;
    logic [BCD_W-1:0]   bcd_acc;
    logic [BCD_W-1:0]   adjusted;
    logic [CNT_W-1:0]   iter;
    logic [BCD_W-1:0]   disp_reg;

    logic [REF_W-1:0]   refresh_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               terminal;
    logic [DIGITS-1:0]  blank_mask;
    logic               zero_above;
    logic [3:0]         next_digit;
    logic               next_blank;
    logic [6:0]         seg_next;
    logic [DIGITS-1:0]  an_next;

    // Converter state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Converter next-state: accept a load only when idle, run DATA_W shifts, then publish
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = SHIFT;
            SHIFT:   if (iter == CNT_W'(DATA_W - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Converter outputs and datapath strobes decoded from the current state
    always_comb begin
        busy   = 1'b0;
        start  = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE: begin
                start = load;
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
            end
            DONE: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Add-3 correction of every nibble that would overflow past 9 after doubling
    always_comb begin
        adjusted = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register pair {bcd, bin}; top bit of the corrected BCD is always zero and is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            bin_reg <= '0;
            bcd_acc <= '0;
            iter    <= '0;
        end else if (start) begin
            bin_reg <= data_in;
            bcd_acc <= '0;
            iter    <= '0;
        end else if (step) begin
            bcd_acc <= BCD_W'({adjusted, bin_reg[DATA_W-1]});
            bin_reg <= {bin_reg[DATA_W-2:0], 1'b0};
            iter    <= iter + 1'b1;
        end
    end

    // Publish a finished conversion to the output and the display in the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_out   <= '0;
            disp_reg  <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= finish;
            if (finish) begin
                bcd_out  <= bcd_acc;
                disp_reg <= bcd_acc;
            end
        end
    end

    // Mark digits above the units that are zero together with everything above them
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (disp_reg[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_above;
        end
    end

    // Work out the slot the scan moves to and what it should show there
    always_comb begin
        terminal   = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
        next_idx   = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        next_digit = 4'd0;
        next_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (next_idx == IDX_W'(i)) begin
                next_digit = disp_reg[4*i +: 4];
                next_blank = blank_mask[i];
            end
        end
        seg_next = (blank_lz && next_blank) ? 7'h7F : seg_decode(next_digit);
        an_next  = ~(DIGITS'(1) << next_idx);
    end

    // Refresh timer and registered anode/segment drive, updated once per slot
    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt  <= '0;
            scan_idx     <= '0;
            AN           <= '1;
            segment_data <= 7'h7F;
        end else if (terminal) begin
            refresh_cnt  <= '0;
            scan_idx     <= next_idx;
            AN           <= an_next;
            segment_data <= seg_next;
        end else begin
            refresh_cnt  <= refresh_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bin_bcd_mux_display.sv
// Randomised self-checking bench for bin_bcd_mux_display: an 8-bit/4-digit
// instance and a 16-bit/5-digit instance, both with a short refresh period,
// compared against an arithmetic reference of conversion and display scan.
module tb_bin_bcd_mux_display;

    localparam int REFRESH_DIV = 4;

    logic        clock;
    logic        reset;
    logic        blank_lz;

    logic [7:0]  data_n;
    logic        load_n;
    logic        busy_n;
    logic        valid_n;
    logic [15:0] bcd_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    logic [15:0] data_w;
    logic        load_w;
    logic        busy_w;
    logic        valid_w;
    logic [19:0] bcd_w;
    logic [6:0]  seg_w;
    logic [4:0]  an_w;

    int check_count;
    int pass_count;
    int edge_count;
    int shown_n;
    int shown_w;

    bin_bcd_mux_display #(.DATA_W(8), .DIGITS(4), .REFRESH_DIV(REFRESH_DIV)) u_dut_n (
        .clock(clock), .reset(reset), .data_in(data_n), .load(load_n),
        .blank_lz(blank_lz), .busy(busy_n), .bcd_valid(valid_n), .bcd_out(bcd_n),
        .segment_data(seg_n), .AN(an_n)
    );

    bin_bcd_mux_display #(.DATA_W(16), .DIGITS(5), .REFRESH_DIV(REFRESH_DIV)) u_dut_w (
        .clock(clock), .reset(reset), .data_in(data_w), .load(load_w),
        .blank_lz(blank_lz), .busy(busy_w), .bcd_valid(valid_w), .bcd_out(bcd_w),
        .segment_data(seg_w), .AN(an_w)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Elapsed clocks since reset released; slot changes every REFRESH_DIV of them
    always @(posedge clock) begin
        if (reset) edge_count <= 0;
        else       edge_count <= edge_count + 1;
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        else
            pass_count++;
    endtask

    // Packed BCD of a value, computed digit by digit with division
    function automatic logic [31:0] refBcd(input int value, input int digits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < digits; i++)
            r = r | (32'((value / (10 ** i)) % 10) << (4 * i));
        return r;
    endfunction

    // Expected anodes/segments after tc completed refresh periods
    function automatic void expectDisplay(input int value, input bit blank, input int digits,
                                          input int tc, output logic [6:0] seg, output logic [7:0] an);
        logic [6:0] table_seg [10];
        logic [7:0] mask;
        int idx;
        int p;
        table_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        mask = 8'((1 << digits) - 1);
        if (tc == 0) begin
            seg = 7'h7F;
            an  = mask;
        end else begin
            idx = tc % digits;
            p   = 10 ** idx;
            an  = ~(8'd1 << idx) & mask;
            if (blank && idx > 0 && value < p) seg = 7'h7F;
            else                               seg = table_seg[(value / p) % 10];
        end
    endfunction

    // Convert one value on the 8-bit instance; optionally poke a second load while busy
    task automatic applyStimulus(input int value, input int poke_at);
        data_n = 8'(value);
        load_n = 1'b1;
        @(negedge clock);
        load_n = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            checkOutput("busy_n", 32'(busy_n), 32'd1);
            checkOutput("valid_n_early", 32'(valid_n), 32'd0);
            load_n = (j == poke_at);
            if (j == poke_at) data_n = 8'd7;
            @(negedge clock);
        end
        load_n = 1'b0;
        checkOutput("busy_n_done", 32'(busy_n), 32'd0);
        checkOutput("valid_n", 32'(valid_n), 32'd1);
        checkOutput("bcd_n", 32'(bcd_n), refBcd(value, 4));
        shown_n = value;
    endtask

    // Convert one value on the 16-bit instance
    task automatic applyWide(input int value);
        data_w = 16'(value);
        load_w = 1'b1;
        @(negedge clock);
        load_w = 1'b0;
        for (int j = 0; j <= 16; j++) begin
            checkOutput("busy_w", 32'(busy_w), 32'd1);
            checkOutput("valid_w_early", 32'(valid_w), 32'd0);
            @(negedge clock);
        end
        checkOutput("busy_w_done", 32'(busy_w), 32'd0);
        checkOutput("valid_w", 32'(valid_w), 32'd1);
        checkOutput("bcd_w", 32'(bcd_w), refBcd(value, 5));
        shown_w = value;
    endtask

    // Let the scan pick up the current values, then follow it for a number of clocks
    task automatic checkDisplay(input int cycles);
        logic [6:0] seg_exp;
        logic [7:0] an_exp;
        int tc;
        repeat (REFRESH_DIV + 1) @(negedge clock);
        for (int c = 0; c < cycles; c++) begin
            tc = edge_count / REFRESH_DIV;
            expectDisplay(shown_n, blank_lz, 4, tc, seg_exp, an_exp);
            checkOutput("an_n", 32'(an_n), 32'(an_exp));
            checkOutput("seg_n", 32'(seg_n), 32'(seg_exp));
            expectDisplay(shown_w, blank_lz, 5, tc, seg_exp, an_exp);
            checkOutput("an_w", 32'(an_w), 32'(an_exp));
            checkOutput("seg_w", 32'(seg_w), 32'(seg_exp));
            @(negedge clock);
        end
    endtask

    // Everything that reset must clear, on both instances
    task automatic checkResetState();
        checkOutput("rst_busy_n", 32'(busy_n), 32'd0);
        checkOutput("rst_valid_n", 32'(valid_n), 32'd0);
        checkOutput("rst_bcd_n", 32'(bcd_n), 32'd0);
        checkOutput("rst_an_n", 32'(an_n), 32'hF);
        checkOutput("rst_seg_n", 32'(seg_n), 32'h7F);
        checkOutput("rst_busy_w", 32'(busy_w), 32'd0);
        checkOutput("rst_bcd_w", 32'(bcd_w), 32'd0);
        checkOutput("rst_an_w", 32'(an_w), 32'h1F);
        checkOutput("rst_seg_w", 32'(seg_w), 32'h7F);
    endtask

    // Directed scenarios first, then randomised conversions with display checks
    initial begin
        int v;
        int poke;
        check_count = 0;
        pass_count  = 0;
        shown_n     = 0;
        shown_w     = 0;
        reset    = 1'b1;
        blank_lz = 1'b0;
        load_n   = 1'b0;
        load_w   = 1'b0;
        data_n   = '0;
        data_w   = '0;
        repeat (3) @(negedge clock);
        checkResetState();
        reset = 1'b0;

        // Scan stays dark until the first refresh period elapses
        repeat (2) @(negedge clock);
        checkOutput("pre_tc_an_n", 32'(an_n), 32'hF);

        applyStimulus(255, -1);
        applyStimulus(0, -1);
        applyStimulus(99, -1);
        applyStimulus(100, 3);

        // Abort a conversion in flight with reset
        data_n = 8'd200;
        load_n = 1'b1;
        @(negedge clock);
        load_n = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        shown_n = 0;
        shown_w = 0;
        checkResetState();
        reset = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            checkOutput("abort_no_valid", 32'(valid_n), 32'd0);
            checkOutput("abort_bcd", 32'(bcd_n), 32'd0);
        end
        applyStimulus(42, -1);

        applyWide(1234);
        blank_lz = 1'b0;
        checkDisplay(2 * 5 * REFRESH_DIV);

        blank_lz = 1'b1;
        applyStimulus(7, -1);
        checkDisplay(2 * 4 * REFRESH_DIV);
        applyStimulus(0, -1);
        checkDisplay(2 * 4 * REFRESH_DIV);

        applyWide(65535);
        checkDisplay(5 * REFRESH_DIV);

        for (int n = 0; n < 20; n++) begin
            v    = int'($urandom_range(0, 255));
            poke = int'($urandom_range(0, 9));
            if (poke == 9) poke = -1;
            applyStimulus(v, poke);
            applyWide(int'($urandom_range(0, 65535)));
            blank_lz = 1'($urandom_range(0, 1));
            checkDisplay(5 * REFRESH_DIV);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
